// File: rtl/axis_sample_fifo.sv
// axis_sample_fifo: first-word-fall-through AXI-Stream sample FIFO.
//   aclk / aresetn    : clock, synchronous active-low reset
//   clear             : synchronous flush (empties FIFO, zeroes overflow_count)
//   s_axis_*          : sample input; tready is constant 1 in drop mode, ~full otherwise
//   m_axis_*          : head-of-queue output, tdata registered and stable while stalled
//   fill_count        : words currently held (0..DEPTH)
//   overflow_count    : words discarded while full, saturating
module axis_sample_fifo #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter bit          DROP_WHEN_FULL = 1'b1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic [31:0]           overflow_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fill_q, fill_d;
  logic [31:0]           ovf_q, ovf_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;

  logic full_c, push_c, pop_c, drop_c;

  // Full comes from the registered count, so a same-cycle pop never frees a slot.
  assign full_c        = (fill_q == CNT_W'(DEPTH));
  assign s_axis_tready = DROP_WHEN_FULL ? 1'b1 : ~full_c;
  assign push_c        = s_axis_tvalid & s_axis_tready & ~full_c & ~clear;
  assign pop_c         = tvalid_q & m_axis_tready & ~clear;
  assign drop_c        = DROP_WHEN_FULL & s_axis_tvalid & full_c & ~clear;

  // Next-state: pointers, occupancy, overflow counter and the head register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      ovf_d    = '0;
      tvalid_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push_c);
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop_c);
      case ({push_c, pop_c})
        2'b10:   fill_d = fill_q + CNT_W'(1);
        2'b01:   fill_d = fill_q - CNT_W'(1);
        default: fill_d = fill_q;
      endcase
      if (drop_c && (ovf_q != 32'hFFFF_FFFF)) ovf_d = ovf_q + 32'd1;
      tvalid_d = (fill_d != '0);
      // Reload the head when it is consumed or empty; if the new head is the
      // word being written this cycle, bypass the memory.
      if (pop_c || !tvalid_q) begin
        if (push_c && (wr_ptr_q == rd_ptr_d)) tdata_d = s_axis_tdata;
        else                                  tdata_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Control and head registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge aclk) begin
    if (push_c) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign fill_count     = fill_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_axis_sample_fifo.sv
// Bench for axis_sample_fifo: instance 0 in drop mode, instance 1 in
// backpressure mode, both 16 deep, each checked against a queue model.
module tb_axis_sample_fifo;

  typedef logic [31:0] word_t;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            clear;
  logic [1:0][31:0] s_data;
  logic [1:0]       s_valid;
  logic [1:0]       s_ready;
  logic [1:0][31:0] m_data;
  logic [1:0]       m_valid;
  logic [1:0]       m_ready;
  logic [1:0][4:0]  fill;
  logic [1:0][31:0] ovf;

  int tests = 0;
  int fails = 0;

  word_t       q0[$];
  word_t       q1[$];
  int unsigned ov0 = 0;
  int unsigned ov1 = 0;
  bit          started = 1'b0;

  always #5 aclk = ~aclk;

  axis_sample_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DROP_WHEN_FULL(1'b1)) u_drop (
    .aclk(aclk), .aresetn(aresetn), .clear(clear),
    .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]),
    .fill_count(fill[0]), .overflow_count(ovf[0])
  );

  axis_sample_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DROP_WHEN_FULL(1'b0)) u_bp (
    .aclk(aclk), .aresetn(aresetn), .clear(clear),
    .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]),
    .fill_count(fill[1]), .overflow_count(ovf[1])
  );

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] t=%0t got %h expected %h", name, i, $time, act, exp);
    end
  endtask

  // Compare DUT outputs with the model, then advance the model by the rules
  // applied at the coming edge using the inputs currently presented.
  task automatic mstep(input int i, ref word_t q[$], ref int unsigned ov);
    bit full, pop, push;
    if (started) begin
      chk("m_axis_tvalid", i, 32'(m_valid[i]), 32'(q.size() != 0));
      chk("fill_count", i, 32'(fill[i]), 32'(q.size()));
      chk("overflow_count", i, ovf[i], ov);
      chk("s_axis_tready", i, 32'(s_ready[i]), (i == 0) ? 32'd1 : 32'(q.size() != 16));
      if (q.size() != 0) chk("m_axis_tdata", i, m_data[i], q[0]);
    end
    if (!aresetn || clear) begin
      q.delete();
      ov = 0;
    end else begin
      full = (q.size() == 16);
      pop  = (q.size() != 0) && m_ready[i];
      push = s_valid[i] && !full;
      if (i == 0 && s_valid[i] && full && ov != 32'hFFFF_FFFF) ov++;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(s_data[i]);
    end
  endtask

  always @(negedge aclk) begin
    mstep(0, q0, ov0);
    mstep(1, q1, ov1);
    started <= 1'b1;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int nxt [2];
    bit acc [2];
    int cyc;
    aresetn = 1'b0; clear = 1'b0;
    s_valid = '0; m_ready = '0; s_data = '0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // Single push into empty FIFO with consumer stalled.
    s_valid = 2'b11; s_data[0] = 32'hA5A5_A5A5; s_data[1] = 32'hA5A5_A5A5;
    tick();
    s_valid = '0;
    repeat (3) tick();
    m_ready = 2'b11; tick(); m_ready = '0; tick();

    // Overfill: 20 words 0..19 with no pops, one pop, then drain.
    for (int k = 0; k < 20; k++) begin
      s_valid = 2'b11; s_data[0] = 32'(k); s_data[1] = 32'(k);
      tick();
    end
    s_valid = '0; tick();
    m_ready = 2'b11; tick(); m_ready = '0; repeat (2) tick();
    m_ready = 2'b11; repeat (20) tick(); m_ready = '0;

    // Steady state at five words with simultaneous push and pop.
    for (int k = 0; k < 5; k++) begin
      s_valid = 2'b11; s_data[0] = 32'(100 + k); s_data[1] = 32'(100 + k);
      tick();
    end
    m_ready = 2'b11;
    for (int k = 0; k < 100; k++) begin
      s_data[0] = 32'(200 + k); s_data[1] = 32'(200 + k);
      tick();
    end
    // Reset with data in flight and a push/pop on the same edge.
    aresetn = 1'b0; tick();
    aresetn = 1'b1; s_valid = '0; repeat (3) tick();
    m_ready = '0;

    // Clear at fill 9 / overflow 3 with a simultaneous push.
    for (int k = 0; k < 19; k++) begin
      s_valid = 2'b11; s_data[0] = 32'(300 + k); s_data[1] = 32'(300 + k);
      tick();
    end
    s_valid = '0;
    m_ready = 2'b11; repeat (7) tick(); m_ready = '0;
    clear = 1'b1; s_valid = 2'b11; s_data[0] = 32'hDEAD_BEEF; s_data[1] = 32'hDEAD_BEEF;
    tick();
    clear = 1'b0; s_data[0] = 32'h0000_1234; s_data[1] = 32'h0000_1234;
    tick();
    s_valid = '0; repeat (2) tick();
    m_ready = 2'b11; repeat (2) tick(); m_ready = '0;

    // Random streaming of 40 incrementing words per instance.
    nxt[0] = 0; nxt[1] = 0;
    cyc = 0;
    while ((nxt[0] < 40 || nxt[1] < 40) && cyc < 3000) begin
      for (int i = 0; i < 2; i++) begin
        acc[i] = s_valid[i] && s_ready[i];
      end
      tick();
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) nxt[i]++;
        if (!s_valid[i] || acc[i]) begin
          s_valid[i] = (nxt[i] < 40) && ($urandom_range(0, 1) == 1);
          s_data[i]  = 32'(1000 + nxt[i]);
        end
        m_ready[i] = ($urandom_range(0, 2) != 0);
      end
    end
    tests++;
    if (nxt[0] < 40 || nxt[1] < 40) begin
      fails++;
      $display("FAIL stream_timeout got %0d/%0d words expected 40/40", nxt[0], nxt[1]);
    end
    s_valid = '0;
    m_ready = 2'b11; repeat (40) tick(); m_ready = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
